// File: rtl/priority_encoder16_to_4.sv
// 16-line request latch with a registered valid/ready index offer and pending popcount.
// Define ROUND_ROBIN_EN to rotate the search start after every grant; the default is fixed priority with bit 15 highest.
module priority_encoder16_to_4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        flush,
  input  logic        ready,
  output logic        valid,
  output logic [3:0]  idx,
  output logic [4:0]  pend_cnt
);

  typedef enum logic {IDLE, OFFER} state_e;

  state_e      state_q;
  logic        valid_q;
  logic [3:0]  idx_q;
  logic [4:0]  cnt_q;
  logic [15:0] pend_q;

  logic        hs;
  logic [15:0] clr;
  logic [15:0] pend_d;
  logic [3:0]  start;
  logic [3:0]  sel_idx;

  // Descending search from 'from' with wrap; the last hit written is the closest to 'from'.
  function automatic logic [3:0] pick(input logic [15:0] v, input logic [3:0] from);
    logic [3:0] res;
    logic [3:0] j;
    res = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      j = from - 4'(15 - i);
      if (v[j]) res = j;
    end
    return res;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 16; i++) acc = acc + {4'b0000, v[i]};
    return acc;
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [3:0] ptr_q;

  // The pointer update takes effect in the same edge's selection, hence the bypass on handshake.
  assign start = hs ? (idx_q - 4'd1) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 4'hF;
    end else if (!flush && hs) begin
      ptr_q <= idx_q - 4'd1;
    end
  end
`else
  assign start = 4'hF;
`endif

  always_comb begin
    hs      = valid_q & ready;
    clr     = '0;
    if (hs) clr[idx_q] = 1'b1;
    pend_d  = (pend_q & ~clr) | req;
    sel_idx = pick(pend_d, start);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= popcount(pend_d);
      case (state_q)
        IDLE: begin
          if (|pend_d) begin
            state_q <= OFFER;
            valid_q <= 1'b1;
            idx_q   <= sel_idx;
          end
        end
        OFFER: begin
          if (ready) begin
            if (|pend_d) begin
              idx_q <= sel_idx;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid    = valid_q;
  assign idx      = idx_q;
  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_priority_encoder16_to_4.sv
// Self-checking bench: set-based reference model compared every cycle, plus directed literal scenarios.
module tb_priority_encoder16_to_4;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        flush;
  logic        ready;
  logic        valid;
  logic [3:0]  idx;
  logic [4:0]  pend_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  // Reference model state: pending requests as a set of flags.
  bit m_pend[16];
  bit m_valid;
  int m_idx;
  int m_ptr;

  priority_encoder16_to_4 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .flush    (flush),
    .ready    (ready),
    .valid    (valid),
    .idx      (idx),
    .pend_cnt (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic int m_pick();
`ifdef ROUND_ROBIN_EN
    for (int k = 0; k < 16; k++) begin
      int j = (m_ptr - k + 32) % 16;
      if (m_pend[j]) return j;
    end
`else
    for (int j = 15; j >= 0; j--) if (m_pend[j]) return j;
`endif
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_pend[i] = 0;
    m_valid = 0;
    m_idx   = 0;
    m_ptr   = 15;
  endtask

  task automatic m_step();
    bit grant;
    if (flush) begin
      for (int i = 0; i < 16; i++) m_pend[i] = 0;
      m_valid = 0;
      m_idx   = 0;
      return;
    end
    grant = m_valid && ready;
    if (grant) begin
      m_pend[m_idx] = 0;
      m_ptr = (m_idx + 15) % 16;
    end
    for (int i = 0; i < 16; i++) if (req[i]) m_pend[i] = 1;
    if (!m_valid || grant) begin
      if (m_count() > 0) begin
        m_valid = 1;
        m_idx   = m_pick();
      end else begin
        m_valid = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_valid", int'(valid), int'(m_valid));
      chk("model_cnt", int'(pend_cnt), m_count());
      if (m_valid) chk("model_idx", int'(idx), m_idx);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    req   = '0;
    flush = 1'b0;
    ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid", int'(valid), 0);
    chk("reset_idx", int'(idx), 0);
    chk("reset_cnt", int'(pend_cnt), 0);
    step();
    rst_n  = 1'b1;
    cmp_en = 1;

    // Single request, one-cycle latency.
    req = 16'h0020; ready = 1'b1;
    step();
    chk("single_valid", int'(valid), 1);
    chk("single_idx", int'(idx), 5);
    chk("single_cnt", int'(pend_cnt), 1);
    req = '0;
    step();
    chk("single_done_valid", int'(valid), 0);
    chk("single_done_cnt", int'(pend_cnt), 0);

    // Fixed priority drain, one grant per cycle.
    req = 16'h8101;
    step();
    chk("prio_idx0", int'(idx), 15);
    chk("prio_cnt0", int'(pend_cnt), 3);
    req = '0;
    step();
    chk("prio_idx1", int'(idx), 8);
    chk("prio_cnt1", int'(pend_cnt), 2);
    step();
    chk("prio_idx2", int'(idx), 0);
    chk("prio_cnt2", int'(pend_cnt), 1);
    step();
    chk("prio_valid_end", int'(valid), 0);
    chk("prio_cnt_end", int'(pend_cnt), 0);

    // Offer holds while not accepted, even against a higher index.
    ready = 1'b0; req = 16'h0004;
    step();
    chk("hold_idx0", int'(idx), 2);
    req = 16'h4000;
    step();
    chk("hold_idx1", int'(idx), 2);
    chk("hold_cnt1", int'(pend_cnt), 2);
    req = '0;
    step();
    chk("hold_idx2", int'(idx), 2);
    ready = 1'b1;
    step();
    chk("hold_next_idx", int'(idx), 14);
    chk("hold_next_cnt", int'(pend_cnt), 1);
    step();
    chk("hold_end_valid", int'(valid), 0);

    // Re-request of the index being accepted keeps it pending.
    ready = 1'b0; req = 16'h0008;
    step();
    chk("setwin_idx0", int'(idx), 3);
    ready = 1'b1;
    step();
    chk("setwin_valid", int'(valid), 1);
    chk("setwin_idx", int'(idx), 3);
    chk("setwin_cnt", int'(pend_cnt), 1);
    req = '0;
    step();
    chk("setwin_end_valid", int'(valid), 0);

    // Flush drops everything including same-cycle requests.
    ready = 1'b0; req = 16'hFFFF;
    step();
    chk("full_cnt", int'(pend_cnt), 16);
`ifndef ROUND_ROBIN_EN
    chk("full_idx", int'(idx), 15);
`endif
    flush = 1'b1; req = 16'h0001; ready = 1'b1;
    step();
    chk("flush_valid", int'(valid), 0);
    chk("flush_cnt", int'(pend_cnt), 0);
    chk("flush_idx", int'(idx), 0);
    flush = 1'b0; req = '0;
    step();
    chk("flush_after_valid", int'(valid), 0);
    chk("flush_after_cnt", int'(pend_cnt), 0);

    // Asynchronous reset mid-offer.
    ready = 1'b0; req = 16'hFFFF;
    step();
    chk("full2_cnt", int'(pend_cnt), 16);
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", int'(valid), 0);
    chk("areset_idx", int'(idx), 0);
    chk("areset_cnt", int'(pend_cnt), 0);
    step();
    rst_n = 1'b1; ready = 1'b1;
    step();
    chk("areset_after_valid", int'(valid), 0);
    chk("areset_after_cnt", int'(pend_cnt), 0);

    // Two requests held continuously with ready high.
    req = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef ROUND_ROBIN_EN
      chk("hold2_idx", int'(idx), (i % 2 == 0) ? 15 : 0);
`else
      chk("hold2_idx", int'(idx), 15);
`endif
      chk("hold2_valid", int'(valid), 1);
    end
    req = '0;
    step();
    step();
    step();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = r & 16'($urandom);
        2: req = 16'h1 << $urandom_range(0, 15);
        default: req = r;
      endcase
      if ($urandom_range(0, 3) == 0) req = '0;
      flush = ($urandom_range(0, 39) == 0);
      ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #3 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    req = '0; flush = 1'b0; ready = 1'b0;
    step();
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
